// File: rtl/cfg_word_pkg.sv
// Shared constants and types for the configuration word stream decoder.
package cfg_word_pkg;

  localparam logic [3:0] OP_WRITE = 4'hA;
  localparam logic [3:0] OP_NOP   = 4'h0;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 28;
  localparam int unsigned LEN_MSB  = 27;
  localparam int unsigned LEN_LSB  = 16;
  localparam int unsigned ADDR_MSB = 15;
  localparam int unsigned ADDR_LSB = 0;

  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;
  localparam int unsigned LEN_W  = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned HADR_W = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic {
    IDLE,
    DATA
  } state_e;

endpackage

// File: rtl/cfg_word_decoder.sv
// Turns header+data configuration bursts into registered register writes,
// with a watchdog against truncated bursts and a saturating error counter.
module cfg_word_decoder
  import cfg_word_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ERR_W       = 16
) (
  input  logic              rdclock,
  input  logic              rdreset_n,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              commit,
  output logic              busy,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

  logic [OP_W-1:0]   hdr_op;
  logic [LEN_W-1:0]  hdr_len;
  logic [HADR_W-1:0] hdr_addr;

  state_e            state_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WD_W-1:0]   wd_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              commit_q;
  logic              err_pulse_q;
  logic [ERR_W-1:0]  err_count_q;

  assign hdr_op   = in_data[OP_MSB:OP_LSB];
  assign hdr_len  = in_data[LEN_MSB:LEN_LSB];
  assign hdr_addr = in_data[ADDR_MSB:ADDR_LSB];

  always_ff @(posedge rdclock or negedge rdreset_n) begin
    if (!rdreset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      commit_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_valid_q  <= 1'b0;
      commit_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (in_valid) begin
            if (hdr_op == OP_WRITE) begin
              if (hdr_len == '0) begin
                commit_q <= 1'b1;
              end else begin
                addr_q      <= hdr_addr[ADDR_W-1:0];
                remaining_q <= hdr_len;
                state_q     <= DATA;
              end
            end else if (hdr_op != OP_NOP) begin
              err_pulse_q <= 1'b1;
              if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
            end
          end
        end
        DATA: begin
          // A valid word in the would-be timeout cycle is data, not an abort.
          if (in_valid) begin
            wd_q        <= '0;
            wr_valid_q  <= 1'b1;
            wr_addr_q   <= addr_q;
            wr_data_q   <= in_data;
            addr_q      <= addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) begin
              commit_q <= 1'b1;
              state_q  <= IDLE;
            end
          end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            wd_q        <= '0;
            err_pulse_q <= 1'b1;
            if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
            state_q     <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign commit    = commit_q;
  assign busy      = (state_q == DATA);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_cfg_word_decoder.sv
// Scoreboard bench for cfg_word_decoder: directed bursts plus random traffic.
module tb_cfg_word_decoder;

  localparam int ADDR_W = 16;
  localparam int TMO    = 8;
  localparam int ERR_W  = 2;
  localparam int EMAX   = (1 << ERR_W) - 1;

  logic              rdclock = 1'b0;
  logic              rdreset_n = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              commit;
  logic              busy;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;

  cfg_word_decoder #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYC(TMO),
    .ERR_W(ERR_W)
  ) dut (
    .rdclock(rdclock),
    .rdreset_n(rdreset_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
    .busy(busy),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 rdclock = ~rdclock;

  typedef struct {
    int          cyc;
    bit          wv;
    int          addr;
    logic [31:0] data;
    bit          cm;
    bit          ep;
  } ev_t;

  typedef struct {
    int cyc;
    bit busy;
    int errs;
  } st_t;

  ev_t ev_q[$];
  st_t st_q[$];

  int checks = 0;
  int failures = 0;
  int posedges = 0;

  always @(posedge rdclock) posedges <= posedges + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, posedges, act, exp);
    end
  endtask

  // Reference model: burst bookkeeping in plain integers.
  bit m_burst = 0;
  int m_rem = 0;
  int m_addr = 0;
  int m_idle = 0;
  int m_errs = 0;

  task automatic model_reset();
    m_burst = 0; m_rem = 0; m_addr = 0; m_idle = 0; m_errs = 0;
    ev_q.delete();
    st_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [31:0] d);
    ev_t e;
    st_t s;
    int op, len;
    e = '{cyc: posedges + 1, wv: 0, addr: 0, data: '0, cm: 0, ep: 0};
    op  = int'(d[31:28]);
    len = int'(d[27:16]);
    if (!m_burst) begin
      if (v) begin
        if (op == 10) begin
          if (len == 0) e.cm = 1;
          else begin
            m_burst = 1; m_rem = len; m_addr = int'(d[15:0]) % (1 << ADDR_W); m_idle = 0;
          end
        end else if (op != 0) begin
          e.ep = 1;
          m_errs = (m_errs < EMAX) ? m_errs + 1 : EMAX;
        end
      end
    end else if (v) begin
      e.wv = 1; e.addr = m_addr; e.data = d;
      m_addr = (m_addr + 1) % (1 << ADDR_W);
      m_rem--; m_idle = 0;
      if (m_rem == 0) begin e.cm = 1; m_burst = 0; end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        e.ep = 1; m_burst = 0; m_idle = 0;
        m_errs = (m_errs < EMAX) ? m_errs + 1 : EMAX;
      end
    end
    if (e.wv || e.cm || e.ep) ev_q.push_back(e);
    s = '{cyc: posedges + 1, busy: m_burst, errs: m_errs};
    st_q.push_back(s);
  endtask

  task automatic step(input bit v, input logic [31:0] d);
    in_valid = v;
    in_data  = v ? d : 32'h0;
    model_step(v, d);
    @(posedge rdclock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_commit"}, commit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_pulse"}, err_pulse, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  // Monitor: per-cycle state, and pulse events popped when the DUT shows one.
  always @(negedge rdclock) begin
    ev_t e;
    st_t s;
    if (rdreset_n) begin
      if (st_q.size() > 0 && st_q[0].cyc == posedges) begin
        s = st_q.pop_front();
        check("busy", busy, s.busy);
        check("err_count", err_count, s.errs);
      end
      if (wr_valid || commit || err_pulse) begin
        if (ev_q.size() == 0) begin
          check("unexpected_event", {wr_valid, commit, err_pulse}, 0);
        end else begin
          e = ev_q.pop_front();
          check("event_cycle", posedges, e.cyc);
          check("wr_valid", wr_valid, e.wv);
          if (e.wv) begin
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
          check("commit", commit, e.cm);
          check("err_pulse", err_pulse, e.ep);
        end
      end else if (ev_q.size() > 0 && ev_q[0].cyc <= posedges) begin
        e = ev_q.pop_front();
        check("missing_event", 0, {e.wv, e.cm, e.ep});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL time_limit: bench did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] w;
    int gap;
    model_reset();
    repeat (2) @(posedge rdclock);
    #1;
    check_reset_outputs("reset");
    rdreset_n = 1'b1;

    // Basic burst
    step(1, 32'hA003_0010);
    step(1, 32'h1); step(1, 32'h2); step(1, 32'h3);
    idle(2);

    // Address wrap with gaps below the timeout
    step(1, 32'hA002_FFFF);
    idle(5); step(1, 32'hCAFE_0001);
    idle(5); step(1, 32'hCAFE_0002);
    idle(2);

    // Truncated burst, then resync
    step(1, 32'hA004_0000);
    step(1, 32'h1111_1111); step(1, 32'h2222_2222);
    idle(10);
    step(1, 32'hA001_0020); step(1, 32'h55);
    idle(2);

    // Illegal opcode, NOP, zero-length write
    step(1, 32'h7000_0000); step(1, 32'h0000_0000); step(1, 32'hA000_0005);
    idle(2);

    // Reset mid-burst
    step(1, 32'hA003_0100); step(1, 32'h0BAD_0001);
    rdreset_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge rdclock);
    #1;
    rdreset_n = 1'b1;
    step(1, 32'hA001_0000); step(1, 32'h600D_0001);
    idle(2);

    // Error counter saturation
    for (int i = 0; i < 5; i++) begin
      w = {4'(1 + (i % 9)), 28'h0};
      step(1, w);
    end
    idle(2);

    // Random traffic, including long silences that trip the watchdog
    for (int n = 0; n < 3000; n++) begin
      if (!m_burst) begin
        if ($urandom_range(0, 99) < 80) begin
          w = $urandom;
          case ($urandom_range(0, 9))
            0:       w[31:28] = 4'h0;
            1:       w[31:28] = 4'h3;
            default: w[31:28] = 4'hA;
          endcase
          w[27:16] = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(0, 40))
                                                  : 12'($urandom_range(0, 6));
          step(1, w);
        end else begin
          step(0, 32'h0);
        end
      end else if ($urandom_range(0, 99) < 4) begin
        gap = $urandom_range(TMO - 2, TMO + 3);
        idle(gap);
      end else begin
        step($urandom_range(0, 99) < 75, $urandom);
      end
    end
    idle(TMO + 4);

    check("leftover_events", ev_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_word_decoder.md
# cfg_word_decoder

Consumes the 32-bit configuration word stream from the dual-clock register FIFO on the `rdclock` side and turns it into register write transactions. Each burst is one header word, with opcode, length and start address, followed by `len` data words. The decoder emits one registered write per data word with an auto-incrementing address, and a commit strobe when the burst completes. The upstream FIFO has no backpressure, so the decoder accepts a word in every valid cycle. It also guards against truncated bursts with a watchdog and counts protocol errors.

## Interface
- `ADDR_W`, default 16: width of `wr_addr`, 1..16.
- `TIMEOUT_CYC`, default 1024: idle cycles allowed inside a burst before it is aborted; must be ≥ 2.
- `ERR_W`, default 16: width of the error counter.

Ports:
- `rdclock`: in, 1. Clock.
- `rdreset_n`: in, 1. Reset, asynchronous, active-low; clock `rdclock`.
- `in_data`: in, 32. Word from the FIFO source.
- `in_valid`: in, 1. Word qualifier; there is no ready signal, so every valid word is consumed.
- `wr_valid`: out, 1. Register write strobe.
- `wr_addr`: out, `ADDR_W`. Write address.
- `wr_data`: out, 32. Write data.
- `commit`: out, 1. One-cycle pulse when a burst completes normally.
- `busy`: out, 1. High while in state DATA.
- `err_pulse`: out, 1. One-cycle pulse for each protocol error.
- `err_count`: out, `ERR_W`. Saturating error count.

## Operation
- **Header format.**
  - `[31:28]` opcode: 4'hA = WRITE, 4'h0 = NOP; any other value is an error.
  - `[27:16]` len, 12 bits.
  - `[15:0]` start address.
- **State IDLE.** Each valid word is a header.
  - WRITE with len > 0: latch address (low `ADDR_W` bits) and `remaining` = len, then go to DATA.
  - WRITE with len = 0: pulse `commit` on the next cycle and stay in IDLE.
  - NOP: ignored.
  - Illegal opcode: `err_pulse` and increment `err_count`; stay in IDLE.
- **State DATA.** Each valid word is data.
  - Emit `wr_valid`/`wr_addr`/`wr_data`.
  - Increment the address modulo 2^`ADDR_W`; wrap-around is legal and silent.
  - Decrement `remaining`. When it reaches 0, return to IDLE and assert `commit` in the same cycle as the last `wr_valid`.
- **Watchdog.** Counts consecutive cycles in DATA with `in_valid` = 0 and clears on every valid word.
  - When the count equals `TIMEOUT_CYC`: abort, pulse `err_pulse`, increment `err_count`, go to IDLE, no `commit`.
  - Writes already issued are not retracted.
  - After an abort, the next word is parsed as a header (resync).
- **`err_count`** saturates at all-ones and never wraps.
- **Reset.** Asserting reset mid-burst drops the burst: no `commit`, no error.

## Timing
- **Reset values.** `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `commit`=0, `busy`=0, `err_pulse`=0, `err_count`=0; state IDLE; watchdog=0.
- **Registered outputs.** All outputs are registered. Latency is 1 cycle: a data word valid at edge N gives `wr_valid` high during cycle N+1.
- **Back-to-back operation.** Back-to-back valid words are sustained at 1 word/cycle with no bubbles.
  - A header directly following the last data word is accepted.
  - Back-to-back writes are possible on consecutive cycles across bursts.
- **Pulse lengths.** `wr_valid`, `commit` and `err_pulse` are each exactly 1 cycle per event.
- **Simultaneous events.**
  - In the cycle the watchdog fires, `in_valid` = 1 wins: the word is accepted as data and the watchdog clears.
  - Increment and saturation of `err_count` in the same cycle: the value holds at max.
- **`busy`** rises 1 cycle after the WRITE header and falls with the last `wr_valid`/`commit`.

## Structure
- **Shared package `cfg_word_pkg`:**
  - opcode constants `OP_WRITE`, `OP_NOP`;
  - field LSB/MSB constants for opcode, len and addr;
  - state enum {IDLE, DATA}.
- **Sub-modules.** Single module; no sub-module is required. The watchdog and saturating counter are inline counters.

## Test plan
- **Basic burst.** Header 32'hA003_0010, then data 1, 2, 3 on consecutive cycles -> writes (0x10,1), (0x11,2), (0x12,3) on 3 consecutive cycles; `commit` with the third; `err_count`=0.
- **Address wrap with gaps.** `ADDR_W`=16, header 32'hA002_FFFF, data with 5-cycle gaps -> addresses 0xFFFF, then 0x0000; `commit` with the second write; no timeout.
- **Truncated burst.** `TIMEOUT_CYC`=8, header 32'hA004_0000, 2 data words, then silence -> 2 writes; `err_pulse` 8 idle cycles after the last word; `busy`=0; no `commit`. A following 32'hA001_0020 plus data 0x55 -> write (0x20,0x55) plus `commit`.
- **Opcodes and zero length.** Stream 32'h7000_0000, 32'h0000_0000, 32'hA000_0005 -> 1 `err_pulse` (`err_count`=1), NOP ignored, `commit` 1 cycle after the third word with no `wr_valid`.
- **Saturation.** `ERR_W`=2, 5 illegal headers -> `err_count` 1, 2, 3, 3, 3; `err_pulse` 5 times.
- **Reset mid-burst.** Assert `rdreset_n`=0 during DATA after 1 of 3 words -> all outputs zero immediately. After release, 32'hA001_0000 plus 1 data word -> normal write plus `commit`.
